// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer around one shared round datapath.
// Accepts a plaintext block, runs NR+1 datapath passes, returns ciphertext.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   key_ready             expanded key table valid, gates acceptance
//   in_valid/in_ready     plaintext handshake, in_data[127:120] = byte 0
//   out_valid/out_ready   ciphertext handshake, out_data held until taken
//   rnd_state/index/mode  drive the round datapath (0 ADDKEY, 1 FULL, 2 FINAL)
//   rnd_result            combinational datapath result
//   busy                  high whenever the sequencer is not idle
module aes_round_ctrl #(
    parameter int NB = 4,
    parameter int NR = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic [32*NB-1:0] rnd_state,
    output logic [3:0]       rnd_index,
    output logic [1:0]       rnd_mode,
    input  logic [32*NB-1:0] rnd_result,
    output logic             busy
);

    localparam int W = 32 * NB;

    localparam logic [3:0] LAST_FULL = 4'(NR - 1);
    localparam logic [3:0] FINAL_IDX = 4'(NR);

    localparam logic [1:0] MODE_ADDKEY = 2'd0;
    localparam logic [1:0] MODE_FULL   = 2'd1;
    localparam logic [1:0] MODE_FINAL  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [3:0]   cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            out_q   <= '0;
            cnt_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        rnd_mode  = MODE_ADDKEY;
        rnd_index = 4'd0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                // reset gates in_ready so nothing looks acceptable while held
                in_ready = key_ready & reset;
                if (in_valid && key_ready && reset) begin
                    state_d = in_data;
                    cnt_d   = 4'd0;
                    fsm_d   = S_INIT;
                end
            end
            S_INIT: begin
                rnd_mode  = MODE_ADDKEY;
                rnd_index = 4'd0;
                state_d   = rnd_result;
                cnt_d     = 4'd1;
                fsm_d     = S_ROUND;
            end
            S_ROUND: begin
                rnd_mode  = MODE_FULL;
                rnd_index = cnt_q;
                state_d   = rnd_result;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == LAST_FULL) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                rnd_mode  = MODE_FINAL;
                rnd_index = FINAL_IDX;
                out_d     = rnd_result;
                fsm_d     = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    assign out_data  = out_q;
    assign rnd_state = state_q;
    assign busy      = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl with a behavioural AES round datapath,
// key expansion and an expected-ciphertext scoreboard.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         key_ready = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [127:0] rnd_state;
    logic [3:0]   rnd_index;
    logic [1:0]   rnd_mode;
    logic [127:0] rnd_result;
    logic         busy;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    logic [127:0] rk [11];
    logic [127:0] sb_q [$];
    int           acc_q [$];
    int           acc_hist [$];
    logic         ov_prev = 1'b0;
    logic         or_prev = 1'b0;

    aes_round_ctrl #(.NB(4), .NR(NR)) dut (
        .clock(clock),
        .reset(reset),
        .key_ready(key_ready),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .rnd_state(rnd_state),
        .rnd_index(rnd_index),
        .rnd_mode(rnd_mode),
        .rnd_result(rnd_result),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, b;
        logic [7:0] e;
        r = 8'h01;
        b = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gm(r, b);
            b = gm(b, b);
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] st,
                                              input logic [127:0] k,
                                              input logic [1:0] mode);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        if (mode == 2'd0) return st ^ k;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = s[r + 4*((c + r) % 4)];
        if (mode == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < NR; r++) s = round_fn(s, rk[r], 2'd1);
        return round_fn(s, rk[NR], 2'd2);
    endfunction

    function automatic logic [127:0] exp_ct(input logic [127:0] pt);
        if (pt == C1_PT) return C1_CT;
        return aes_model(pt);
    endfunction

    task automatic key_expand();
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]),
                       sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++)
            rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    always_comb begin
        rnd_result = '0;
        if (rnd_index <= 4'd10)
            rnd_result = round_fn(rnd_state, rk[rnd_index], rnd_mode);
    end

    always @(negedge reset) begin
        sb_q.delete();
        acc_q.delete();
    end

    always @(negedge clock) begin
        if (reset) begin
            if (in_valid && in_ready) begin
                sb_q.push_back(exp_ct(in_data));
                acc_q.push_back(cyc + 1);
                acc_hist.push_back(cyc + 1);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) chk("lat_noaccept", 128'd0, 128'd1);
                else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(NR + 1));
            end
            if (ov_prev && !or_prev) chk("ov_hold", 128'(out_valid), 128'd1);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("sb_empty", out_data, 128'd0);
                else chk("ciphertext", out_data, sb_q.pop_front());
            end
            ov_prev <= out_valid;
            or_prev <= out_ready;
        end else begin
            ov_prev <= 1'b0;
            or_prev <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        in_data = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'd0, 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        int bcnt;
        bit ok;
        key_expand();
        key_ready = 1'b1;
        #23;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        step();
        reset = 1'b1;
        step();

        // FIPS-197 C.1 with round sequencing and busy length
        out_ready = 1'b1;
        send(C1_PT);
        bcnt = 0;
        for (int i = 0; i <= NR; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (i == 0) begin
                chk("seq_mode", 128'(rnd_mode), 128'd0);
                chk("seq_index", 128'(rnd_index), 128'd0);
            end else if (i == NR) begin
                chk("seq_mode", 128'(rnd_mode), 128'd2);
                chk("seq_index", 128'(rnd_index), 128'(NR));
            end else begin
                chk("seq_mode", 128'(rnd_mode), 128'd1);
                chk("seq_index", 128'(rnd_index), 128'(i));
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!busy) break;
            bcnt++;
        end
        chk("busy_cycles", 128'(bcnt), 128'd12);
        wait_idle();

        // back-pressure
        step();
        out_ready = 1'b0;
        send(C1_PT);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bp_timeout", 128'd0, 128'd1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_data", out_data, C1_CT);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            @(negedge clock);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clock);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        wait_idle();

        // key_ready gating
        step();
        key_ready = 1'b0;
        in_data = C1_PT;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("kr_in_ready", 128'(in_ready), 128'd0);
            chk("kr_busy", 128'(busy), 128'd0);
        end
        step();
        key_ready = 1'b1;
        @(negedge clock);
        chk("kr_accept", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("kr_busy_after", 128'(busy), 128'd1);
        wait_idle();

        // reset in the middle of ROUND cnt=5
        step();
        send(C1_PT);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rnd_mode == 2'd1 && rnd_index == 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rst_mid_timeout", 128'd0, 128'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_out_data", out_data, 128'd0);
        chk("mid_rst_state", rnd_state, 128'd0);
        chk("mid_rst_mode", 128'(rnd_mode), 128'd0);
        step();
        step();
        reset = 1'b1;
        send(C1_PT);
        wait_idle();

        // back-to-back accepts with in_valid held high
        step();
        in_data = C1_PT;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        in_data = '0;
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b0;
                break;
            end
        end
        if (ok) chk("b2b_timeout", 128'd0, 128'd1);
        step();
        in_valid = 1'b0;
        if (acc_hist.size() >= 2)
            chk("b2b_spacing",
                128'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]),
                128'(NR + 3));
        else
            chk("b2b_count", 128'(acc_hist.size()), 128'd2);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
